// File: rtl/hs_cdc_tx.sv
// hs_cdc_tx: domain-A source side of a multi-bit req/ack clock-domain crossing.
// Words are queued in a small FIFO and sent with four-phase (MODE=0) or two-phase (MODE=1) signalling.
module hs_cdc_tx #(
    parameter int DATA_W      = 8,
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2,
    parameter int MODE        = 0,
    parameter int TIMEOUT     = 1023
) (
    input  logic                        i_clk_a,
    input  logic                        i_rst_n,
    input  logic [DATA_W-1:0]           i_data,
    input  logic                        i_valid,
    output logic                        o_ready,
    output logic [$clog2(FIFO_DEPTH):0] o_level,
    input  logic                        i_data_ack,
    output logic [DATA_W-1:0]           o_data,
    output logic                        o_data_req,
    output logic                        o_busy,
    output logic                        o_timeout,
    input  logic                        i_err_clr
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = (TIMEOUT > 32'sd0) ? $clog2(TIMEOUT + 32'sd1) : 1;
    localparam bit TWO_PHASE = (MODE != 32'sd0);
    localparam bit TO_EN     = (TIMEOUT != 32'sd0);
    localparam logic [LW-1:0] DEPTH_L = LW'(FIFO_DEPTH);
    localparam logic [CW-1:0] TO_MAX  = CW'(TIMEOUT);
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 32'sd1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETUP   = 2'd1,
        ST_WAIT_HI = 2'd2,
        ST_WAIT_LO = 2'd3
    } state_t;

    state_t                 state_r, state_nxt_s;
    logic [SYNC_STAGES-1:0] ack_sync_r;
    logic                   ack_s;
    logic [DATA_W-1:0]      mem_r [FIFO_DEPTH];
    logic [LW-1:0]          wptr_r, rptr_r, level_r;
    logic [LW-1:0]          wptr_nxt_s, rptr_nxt_s, level_nxt_s;
    logic                   ready_r, empty_s, wr_s, pop_s;
    logic [DATA_W-1:0]      data_r, data_nxt_s;
    logic                   req_r, req_nxt_s, busy_r, timeout_r, to_set_s;
    logic [CW-1:0]          to_cnt_r, to_cnt_nxt_s;

    assign ack_s       = ack_sync_r[SYNC_STAGES-1];
    assign empty_s     = (wptr_r == rptr_r);
    assign wr_s        = i_valid & ready_r;
    assign wptr_nxt_s  = wptr_r + LW'(wr_s);
    assign rptr_nxt_s  = rptr_r + LW'(pop_s);
    assign level_nxt_s = wptr_nxt_s - rptr_nxt_s;

    assign o_ready    = ready_r;
    assign o_level    = level_r;
    assign o_data     = data_r;
    assign o_data_req = req_r;
    assign o_busy     = busy_r;
    assign o_timeout  = timeout_r;

    // Ack synchroniser chain; the FSM only ever looks at the last stage.
    always_ff @(posedge i_clk_a or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ack_sync_r <= {SYNC_STAGES{1'b0}};
        end else begin
            ack_sync_r <= {ack_sync_r[SYNC_STAGES-2:0], i_data_ack};
        end
    end

    // FIFO storage, pointers and registered occupancy/ready.
    always_ff @(posedge i_clk_a or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wptr_r  <= {LW{1'b0}};
            rptr_r  <= {LW{1'b0}};
            level_r <= {LW{1'b0}};
            ready_r <= 1'b1;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= {DATA_W{1'b0}};
            end
        end else begin
            if (wr_s) begin
                mem_r[wptr_r[AW-1:0]] <= i_data;
            end
            wptr_r  <= wptr_nxt_s;
            rptr_r  <= rptr_nxt_s;
            level_r <= level_nxt_s;
            ready_r <= (level_nxt_s != DEPTH_L);
        end
    end

    // FSM state register.
    always_ff @(posedge i_clk_a or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; two-phase mode completes straight from WAIT_HI.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (!empty_s) state_nxt_s = ST_SETUP;
                else          state_nxt_s = ST_IDLE;
            end
            ST_SETUP: state_nxt_s = ST_WAIT_HI;
            ST_WAIT_HI: begin
                if (TWO_PHASE) begin
                    if (ack_s == req_r) state_nxt_s = ST_IDLE;
                    else                state_nxt_s = ST_WAIT_HI;
                end else begin
                    if (ack_s) state_nxt_s = ST_WAIT_LO;
                    else       state_nxt_s = ST_WAIT_HI;
                end
            end
            ST_WAIT_LO: begin
                if (!ack_s) state_nxt_s = ST_IDLE;
                else        state_nxt_s = ST_WAIT_LO;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Output next-values: payload only changes on IDLE->SETUP, a cycle ahead of req.
    always_comb begin
        pop_s      = 1'b0;
        data_nxt_s = data_r;
        req_nxt_s  = req_r;
        case (state_r)
            ST_IDLE: begin
                if (!empty_s) begin
                    pop_s      = 1'b1;
                    data_nxt_s = mem_r[rptr_r[AW-1:0]];
                end else begin
                    pop_s      = 1'b0;
                    data_nxt_s = data_r;
                end
            end
            ST_SETUP: req_nxt_s = TWO_PHASE ? ~req_r : 1'b1;
            ST_WAIT_HI: begin
                if (!TWO_PHASE && ack_s) req_nxt_s = 1'b0;
                else                     req_nxt_s = req_r;
            end
            ST_WAIT_LO: req_nxt_s = req_r;
            default: begin
                pop_s      = 1'b0;
                data_nxt_s = data_r;
                req_nxt_s  = req_r;
            end
        endcase
    end

    // Wait-time counter: restarts on any state change, saturates at TIMEOUT.
    always_comb begin
        to_cnt_nxt_s = to_cnt_r;
        to_set_s     = 1'b0;
        if (state_nxt_s != state_r) begin
            to_cnt_nxt_s = {CW{1'b0}};
        end else if ((state_r == ST_WAIT_HI) || (state_r == ST_WAIT_LO)) begin
            if (to_cnt_r != TO_MAX) to_cnt_nxt_s = to_cnt_r + CW'(1'b1);
            else                    to_cnt_nxt_s = to_cnt_r;
            to_set_s = TO_EN && (to_cnt_r == TO_LAST);
        end else begin
            to_cnt_nxt_s = to_cnt_r;
        end
    end

    // Registered outputs and sticky timeout (set beats clear).
    always_ff @(posedge i_clk_a or negedge i_rst_n) begin
        if (!i_rst_n) begin
            data_r    <= {DATA_W{1'b0}};
            req_r     <= 1'b0;
            busy_r    <= 1'b0;
            timeout_r <= 1'b0;
            to_cnt_r  <= {CW{1'b0}};
        end else begin
            data_r   <= data_nxt_s;
            req_r    <= req_nxt_s;
            busy_r   <= (state_nxt_s != ST_IDLE);
            to_cnt_r <= to_cnt_nxt_s;
            if (to_set_s)       timeout_r <= 1'b1;
            else if (i_err_clr) timeout_r <= 1'b0;
            else                timeout_r <= timeout_r;
        end
    end

endmodule

// File: tb/tb_hs_cdc_tx.sv
// Directed bench for hs_cdc_tx: four-phase instance (TIMEOUT=10) with a delayed ack model,
// and a two-phase instance whose ack mirrors req.
`timescale 1ns/1ps
module tb_hs_cdc_tx;
    logic       clk = 1'b0;
    logic       rst_n;
    int         nvec = 0;
    int         nerr = 0;

    always #5 clk = ~clk;

    logic [7:0] data0, odata0, data1, odata1;
    logic       valid0, ready0, ack0, req0, busy0, tout0, clr0;
    logic       valid1, ready1, ack1, req1, busy1, tout1, clr1;
    logic [2:0] level0, level1;
    logic       ack_en0;
    logic [2:0] req_hist0;
    logic       req0_q;
    logic [7:0] got0[$];

    hs_cdc_tx #(.DATA_W(8), .FIFO_DEPTH(4), .SYNC_STAGES(2), .MODE(0), .TIMEOUT(10)) u_dut0 (
        .i_clk_a(clk), .i_rst_n(rst_n), .i_data(data0), .i_valid(valid0), .o_ready(ready0),
        .o_level(level0), .i_data_ack(ack0), .o_data(odata0), .o_data_req(req0),
        .o_busy(busy0), .o_timeout(tout0), .i_err_clr(clr0));

    hs_cdc_tx #(.DATA_W(8), .FIFO_DEPTH(4), .SYNC_STAGES(2), .MODE(1), .TIMEOUT(1023)) u_dut1 (
        .i_clk_a(clk), .i_rst_n(rst_n), .i_data(data1), .i_valid(valid1), .o_ready(ready1),
        .o_level(level1), .i_data_ack(ack1), .o_data(odata1), .o_data_req(req1),
        .o_busy(busy1), .o_timeout(tout1), .i_err_clr(clr1));

    // Domain-B model: ack follows req three cycles later, reset together with the DUT.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) req_hist0 <= 3'b000;
        else        req_hist0 <= {req_hist0[1:0], req0};
    end
    assign ack0 = ack_en0 & req_hist0[2];
    assign ack1 = req1;

    // Record every word presented on a rising req of the four-phase instance.
    always @(posedge clk) begin
        req0_q <= req0;
        if (req0 && !req0_q) got0.push_back(odata0);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; valid0 = 1'b0; valid1 = 1'b0; data0 = 8'h00; data1 = 8'h00;
        clr0 = 1'b0; clr1 = 1'b0; ack_en0 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        nvec++; if (level0 !== 3'd0) begin nerr++; $display("FAIL rst_level: got %0d want 0", level0); end
        nvec++; if (ready0 !== 1'b1) begin nerr++; $display("FAIL rst_ready: got %b want 1", ready0); end
        nvec++; if (odata0 !== 8'h00) begin nerr++; $display("FAIL rst_data: got %h want 00", odata0); end
        nvec++; if (req0 !== 1'b0) begin nerr++; $display("FAIL rst_req: got %b want 0", req0); end
        nvec++; if (busy0 !== 1'b0) begin nerr++; $display("FAIL rst_busy: got %b want 0", busy0); end
        nvec++; if (tout0 !== 1'b0) begin nerr++; $display("FAIL rst_timeout: got %b want 0", tout0); end
        nvec++; if (req1 !== 1'b0 || ready1 !== 1'b1) begin nerr++; $display("FAIL rst_dut1: got req=%b rdy=%b want 0/1", req1, ready1); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single_word();
        data0 = 8'hA5; valid0 = 1'b1;
        tick();                         // edge N: write
        valid0 = 1'b0;
        nvec++; if (level0 !== 3'd1) begin nerr++; $display("FAIL sw_level: got %0d want 1", level0); end
        tick();                         // N+1: load
        nvec++; if (odata0 !== 8'hA5) begin nerr++; $display("FAIL sw_data: got %h want a5", odata0); end
        nvec++; if (req0 !== 1'b0) begin nerr++; $display("FAIL sw_req_n1: got %b want 0", req0); end
        tick();                         // N+2: req up
        nvec++; if (req0 !== 1'b1) begin nerr++; $display("FAIL sw_req_n2: got %b want 1", req0); end
        repeat (5) tick();              // N+7: ack sampled at N+6, not yet through the synchroniser
        nvec++; if (req0 !== 1'b1) begin nerr++; $display("FAIL sw_req_n7: got %b want 1", req0); end
        tick();                         // N+8: req falls
        nvec++; if (req0 !== 1'b0) begin nerr++; $display("FAIL sw_req_n8: got %b want 0", req0); end
        repeat (5) tick();              // N+13: still waiting for ack_s low
        nvec++; if (busy0 !== 1'b1) begin nerr++; $display("FAIL sw_busy_n13: got %b want 1", busy0); end
        tick();                         // N+14: back in IDLE
        nvec++; if (busy0 !== 1'b0) begin nerr++; $display("FAIL sw_busy_n14: got %b want 0", busy0); end
        nvec++; if (tout0 !== 1'b0) begin nerr++; $display("FAIL sw_timeout: got %b want 0", tout0); end
    endtask

    task automatic test_timeout();
        bit ok;
        got0.delete();
        ack_en0 = 1'b0;
        data0 = 8'h5A; valid0 = 1'b1;
        tick();                         // edge N
        valid0 = 1'b0;
        repeat (11) tick();             // N+11: 9 cycles into WAIT_HI
        nvec++; if (tout0 !== 1'b0) begin nerr++; $display("FAIL to_early: got %b want 0", tout0); end
        clr0 = 1'b1;
        tick();                         // N+12: set and clear together
        clr0 = 1'b0;
        nvec++; if (tout0 !== 1'b1) begin nerr++; $display("FAIL to_set: got %b want 1", tout0); end
        nvec++; if (req0 !== 1'b1) begin nerr++; $display("FAIL to_req_held: got %b want 1", req0); end
        ack_en0 = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 60; k++) begin
            tick();
            if (busy0 === 1'b0) begin ok = 1'b1; break; end
        end
        nvec++; if (ok !== 1'b1) begin nerr++; $display("FAIL to_complete: got busy=%b want 0", busy0); end
        nvec++; if (tout0 !== 1'b1) begin nerr++; $display("FAIL to_sticky: got %b want 1", tout0); end
        nvec++; if (got0.size() !== 1 || got0[0] !== 8'h5A) begin nerr++; $display("FAIL to_word: got n=%0d want 1 word 5a", got0.size()); end
        clr0 = 1'b1;
        tick();
        clr0 = 1'b0;
        nvec++; if (tout0 !== 1'b0) begin nerr++; $display("FAIL to_clear: got %b want 0", tout0); end
    endtask

    task automatic test_fill_burst();
        bit ok;
        logic [2:0] exp_lvl;
        logic       exp_rdy;
        got0.delete();
        ack_en0 = 1'b0;
        valid0 = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            data0 = 8'(i);
            tick();
            exp_lvl = (i == 1) ? 3'd1 : 3'(i - 1);
            exp_rdy = (i == 5) ? 1'b0 : 1'b1;
            nvec++; if (level0 !== exp_lvl) begin nerr++; $display("FAIL fill_level[%0d]: got %0d want %0d", i, level0, exp_lvl); end
            nvec++; if (ready0 !== exp_rdy) begin nerr++; $display("FAIL fill_ready[%0d]: got %b want %b", i, ready0, exp_rdy); end
        end
        data0 = 8'h06;
        tick();                         // refused: FIFO full
        valid0 = 1'b0;
        nvec++; if (level0 !== 3'd4 || ready0 !== 1'b0) begin nerr++; $display("FAIL fill_refuse: got lvl=%0d rdy=%b want 4/0", level0, ready0); end
        ack_en0 = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 300; k++) begin
            tick();
            if (busy0 === 1'b0 && level0 === 3'd0) begin ok = 1'b1; break; end
        end
        nvec++; if (ok !== 1'b1) begin nerr++; $display("FAIL fill_drain: got lvl=%0d busy=%b want 0/0", level0, busy0); end
        nvec++; if (got0.size() !== 5) begin nerr++; $display("FAIL fill_count: got %0d want 5", got0.size()); end
        for (int i = 0; i < 5 && i < got0.size(); i++) begin
            nvec++; if (got0[i] !== 8'(i + 1)) begin nerr++; $display("FAIL fill_order[%0d]: got %h want %h", i, got0[i], 8'(i + 1)); end
        end
        clr0 = 1'b1;
        tick();
        clr0 = 1'b0;
    endtask

    task automatic test_write_pop();
        bit ok;
        logic [7:0] exp_w;
        got0.delete();
        ack_en0 = 1'b0;
        valid0 = 1'b1;
        data0 = 8'hC1; tick();
        data0 = 8'hC2; tick();
        data0 = 8'hC3; tick();
        valid0 = 1'b0;
        nvec++; if (level0 !== 3'd2) begin nerr++; $display("FAIL wp_pre_level: got %0d want 2", level0); end
        ack_en0 = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 50; k++) begin
            tick();
            if (busy0 === 1'b0) begin ok = 1'b1; break; end
        end
        nvec++; if (ok !== 1'b1) begin nerr++; $display("FAIL wp_idle: got busy=%b want 0", busy0); end
        data0 = 8'hC4; valid0 = 1'b1;
        tick();                         // write and pop on the same edge
        valid0 = 1'b0;
        nvec++; if (level0 !== 3'd2) begin nerr++; $display("FAIL wp_level: got %0d want 2", level0); end
        nvec++; if (odata0 !== 8'hC2) begin nerr++; $display("FAIL wp_head: got %h want c2", odata0); end
        ok = 1'b0;
        for (int k = 0; k < 200; k++) begin
            tick();
            if (busy0 === 1'b0 && level0 === 3'd0) begin ok = 1'b1; break; end
        end
        nvec++; if (ok !== 1'b1 || got0.size() !== 4) begin nerr++; $display("FAIL wp_drain: got n=%0d want 4", got0.size()); end
        for (int i = 0; i < 4 && i < got0.size(); i++) begin
            exp_w = 8'hC1 + 8'(i);
            nvec++; if (got0[i] !== exp_w) begin nerr++; $display("FAIL wp_order[%0d]: got %h want %h", i, got0[i], exp_w); end
        end
        clr0 = 1'b1;
        tick();
        clr0 = 1'b0;
    endtask

    task automatic test_reset_mid();
        bit ok;
        ack_en0 = 1'b0;
        valid0 = 1'b1;
        data0 = 8'hD1; tick();
        data0 = 8'hD2; tick();
        data0 = 8'hD3; tick();
        valid0 = 1'b0;
        nvec++; if (req0 !== 1'b1 || level0 !== 3'd2) begin nerr++; $display("FAIL rm_pre: got req=%b lvl=%0d want 1/2", req0, level0); end
        #2;
        rst_n = 1'b0;
        #1;
        nvec++; if (req0 !== 1'b0) begin nerr++; $display("FAIL rm_req: got %b want 0", req0); end
        nvec++; if (odata0 !== 8'h00) begin nerr++; $display("FAIL rm_data: got %h want 00", odata0); end
        nvec++; if (level0 !== 3'd0 || ready0 !== 1'b1) begin nerr++; $display("FAIL rm_fifo: got lvl=%0d rdy=%b want 0/1", level0, ready0); end
        nvec++; if (busy0 !== 1'b0) begin nerr++; $display("FAIL rm_busy: got %b want 0", busy0); end
        tick();
        rst_n = 1'b1;
        ack_en0 = 1'b1;
        got0.delete();
        data0 = 8'h3C; valid0 = 1'b1;
        tick();
        valid0 = 1'b0;
        ok = 1'b0;
        for (int k = 0; k < 60; k++) begin
            tick();
            if (busy0 === 1'b0 && level0 === 3'd0) begin ok = 1'b1; break; end
        end
        nvec++; if (ok !== 1'b1 || got0.size() !== 1 || got0[0] !== 8'h3C) begin nerr++; $display("FAIL rm_resume: got n=%0d want 1 word 3c", got0.size()); end
    endtask

    task automatic test_mode1_toggle();
        logic [16:0] req_tab;
        logic [16:0] busy_tab;
        logic [7:0]  exp_d;
        req_tab  = 17'b11111000001111100;
        busy_tab = 17'b00111101111011110;
        for (int i = 0; i < 17; i++) begin
            if (i < 3) begin valid1 = 1'b1; data1 = 8'(8'h11 * (i + 1)); end
            else       begin valid1 = 1'b0; end
            tick();
            nvec++; if (req1 !== req_tab[i]) begin nerr++; $display("FAIL m1_req[%0d]: got %b want %b", i, req1, req_tab[i]); end
            nvec++; if (busy1 !== busy_tab[i]) begin nerr++; $display("FAIL m1_busy[%0d]: got %b want %b", i, busy1, busy_tab[i]); end
            if (i == 1 || i == 6 || i == 11) begin
                exp_d = 8'(8'h11 * ((i - 1) / 5 + 1));
                nvec++; if (odata1 !== exp_d) begin nerr++; $display("FAIL m1_data[%0d]: got %h want %h", i, odata1, exp_d); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_timeout();
        test_fill_burst();
        test_write_pop();
        test_mode1_toggle();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
